stopwatch_display: RTL and testbench

- MM:SS stopwatch and 4-digit seven-segment scanner.
- Sits directly downstream of the clock divider and consumes its two square-wave outputs: the 500 Hz wave drives digit scanning, the 1 Hz wave drives the count.
- Runs entirely on the 50 MHz board clock. Both divider outputs are treated as synchronous level signals and edge-detected locally.
- Drives the board's common-anode display pins directly.

---
 rtl/stopwatch_display_pkg.sv | 34 +++
 rtl/stopwatch_display_bcd_to_seg7.sv | 26 ++
 rtl/stopwatch_display.sv | 156 +++++++++++++++
 tb/tb_stopwatch_display.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_display_pkg.sv
// Shared constants and types for the MM:SS stopwatch and its seven-segment scanner.
package stopwatch_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 2;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic [BCD_W-1:0] min_t;
    logic [BCD_W-1:0] min_u;
    logic [BCD_W-1:0] sec_t;
    logic [BCD_W-1:0] sec_u;
  } bcd_time_t;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

endpackage

// File: rtl/stopwatch_display_bcd_to_seg7.sv
// Combinational BCD to active-high seven-segment decoder; non-BCD codes blank the digit.
module bcd_to_seg7
  import stopwatch_display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg_c = SEG_0;
      4'd1: o_seg_c = SEG_1;
      4'd2: o_seg_c = SEG_2;
      4'd3: o_seg_c = SEG_3;
      4'd4: o_seg_c = SEG_4;
      4'd5: o_seg_c = SEG_5;
      4'd6: o_seg_c = SEG_6;
      4'd7: o_seg_c = SEG_7;
      4'd8: o_seg_c = SEG_8;
      4'd9: o_seg_c = SEG_9;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch counting on 1 Hz rises, scanning a 4-digit common-anode display on 500 Hz rises.
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int unsigned MAX_MINUTES    = 59,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clock500Hz,
  input  logic                  Clock1Hz,
  input  logic                  startStop,
  input  logic                  clear,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  running,
  output logic                  rollover
);

  localparam logic [BCD_W-1:0]      MAX_MIN_T = BCD_W'(MAX_MINUTES / 10);
  localparam logic [BCD_W-1:0]      MAX_MIN_U = BCD_W'(MAX_MINUTES % 10);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = SEG_ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam logic [SEG_W-1:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic                  DP_ON     = SEG_ACTIVE_LOW ? 1'b0 : 1'b1;

  logic                  r_prev1;
  logic                  r_prev500;
  logic                  r_tick1;
  logic                  r_tick500;
  run_state_t            r_state;
  run_state_t            w_state_nxt;
  bcd_time_t             r_time;
  bcd_time_t             w_time_nxt;
  logic                  w_wrap;
  logic                  w_at_max;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rollover;
  logic [BCD_W-1:0]      w_digit;
  logic [SEG_W-1:0]      w_seg_c;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_dp;

  // History resets high so an input already high at release is not seen as a rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev1   <= 1'b1;
      r_prev500 <= 1'b1;
      r_tick1   <= 1'b0;
      r_tick500 <= 1'b0;
    end else begin
      r_prev1   <= Clock1Hz;
      r_prev500 <= clock500Hz;
      r_tick1   <= Clock1Hz & ~r_prev1;
      r_tick500 <= clock500Hz & ~r_prev500;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_STOPPED;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (startStop) begin
      w_state_nxt = (r_state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
  end

  // Minutes ceiling also caps at 59 so the tens digit can never leave 0..5
  assign w_at_max = (r_time.sec_t == 4'd5) && (r_time.sec_u == 4'd9) &&
                    (((r_time.min_t == MAX_MIN_T) && (r_time.min_u == MAX_MIN_U)) ||
                     ((r_time.min_t == 4'd5) && (r_time.min_u == 4'd9)));

  always_comb begin
    w_time_nxt = r_time;
    w_wrap     = 1'b0;
    if (clear) begin
      w_time_nxt = '0;
    end else if (r_tick1 && (r_state == ST_RUNNING)) begin
      if (w_at_max) begin
        w_time_nxt = '0;
        w_wrap     = 1'b1;
      end else if (r_time.sec_u != 4'd9) begin
        w_time_nxt.sec_u = r_time.sec_u + 4'd1;
      end else begin
        w_time_nxt.sec_u = 4'd0;
        if (r_time.sec_t != 4'd5) begin
          w_time_nxt.sec_t = r_time.sec_t + 4'd1;
        end else begin
          w_time_nxt.sec_t = 4'd0;
          if (r_time.min_u != 4'd9) begin
            w_time_nxt.min_u = r_time.min_u + 4'd1;
          end else begin
            w_time_nxt.min_u = 4'd0;
            w_time_nxt.min_t = r_time.min_t + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_time     <= '0;
      r_rollover <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_time     <= w_time_nxt;
      r_rollover <= w_wrap;
      if (r_tick500) r_idx <= r_idx + 2'd1;
    end
  end

  always_comb begin
    w_digit = r_time.sec_u;
    case (r_idx)
      2'd0: w_digit = r_time.sec_u;
      2'd1: w_digit = r_time.sec_t;
      2'd2: w_digit = r_time.min_u;
      2'd3: w_digit = r_time.min_t;
      default: w_digit = r_time.sec_u;
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd   (w_digit),
    .o_seg_c (w_seg_c)
  );

  assign w_an_hot = NUM_DIGITS'(4'b0001 << r_idx);

  // Display pins follow index/counter changes one cycle later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an  <= SEG_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg_c : w_seg_c;
      r_dp  <= (r_idx == 2'd2) ? DP_ON : DP_OFF;
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign dp       = r_dp;
  assign running  = (r_state == ST_RUNNING);
  assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display against a seconds-count reference model.
module tb_stopwatch_display;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clock500Hz;
  logic       Clock1Hz;
  logic       startStop;
  logic       clear;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       running;
  logic       rollover;

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed seconds modulo one hour, run flag, scan slot
  int m_secs = 0;
  bit m_run  = 1'b0;
  int m_scan = 0;

  always #10 clock = ~clock;

  stopwatch_display dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clock500Hz (clock500Hz),
    .Clock1Hz   (Clock1Hz),
    .startStop  (startStop),
    .clear      (clear),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .running    (running),
    .rollover   (rollover)
  );

  function automatic int seg_digit(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int ix);
    case (ix)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int exp_digit(input int secs, input int ix);
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    case (ix)
      0: return ss % 10;
      1: return ss / 10;
      2: return mm % 10;
      default: return mm / 10;
    endcase
  endfunction

  function automatic int exp_mmss();
    return (m_secs / 60) * 100 + (m_secs % 60);
  endfunction

  task automatic pulse_1hz();
    Clock1Hz = 1'b1;
    @(negedge clock);
    Clock1Hz = 1'b0;
    @(negedge clock);
    @(negedge clock);
    if (m_run) m_secs = (m_secs + 1) % 3600;
  endtask

  task automatic pulse_500();
    clock500Hz = 1'b1;
    @(negedge clock);
    clock500Hz = 1'b0;
    @(negedge clock);
    @(negedge clock);
    m_scan = (m_scan + 1) % 4;
  endtask

  task automatic pulse_start();
    startStop = 1'b1;
    @(negedge clock);
    startStop = 1'b0;
    @(negedge clock);
    m_run = !m_run;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    m_secs = 0;
  endtask

  task automatic set_running(input bit want);
    if (m_run != want) pulse_start();
  endtask

  // Scans all four slots and returns the shown value as MMSS, or -1 if unreadable
  task automatic read_display(output int value);
    int d[4];
    int ix;
    for (int k = 0; k < 4; k++) d[k] = -1;
    for (int k = 0; k < 4; k++) begin
      pulse_500();
      ix = an_index(an);
      if (ix >= 0) d[ix] = seg_digit(seg);
    end
    if (d[0] < 0 || d[1] < 0 || d[2] < 0 || d[3] < 0) value = -1;
    else value = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    clock500Hz = 1'b0;
    Clock1Hz   = 1'b0;
    startStop  = 1'b0;
    clear      = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL rst_an: got %b want 1111", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL rst_seg: got %b want 1111111", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp: got %b want 1", dp); end
    total++; if (running !== 1'b0 || rollover !== 1'b0) begin
      bad++; $display("FAIL rst_flags: got run=%b roll=%b want 0 0", running, rollover);
    end
    reset_n = 1'b1;
    m_secs = 0; m_run = 1'b0; m_scan = 0;
    @(negedge clock);
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL idle_an: got %b want 1110", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL idle_seg: got %b want 1000000", seg); end
    total++; if (dp !== 1'b1 || running !== 1'b0) begin
      bad++; $display("FAIL idle_dp_run: got dp=%b run=%b want 1 0", dp, running);
    end
  endtask

  task automatic test_start_count();
    repeat (2) pulse_1hz();
    total++; if (seg !== digit_pattern(exp_digit(m_secs, 0))) begin
      bad++; $display("FAIL stopped_ticks: got %b want %b", seg, digit_pattern(exp_digit(m_secs, 0)));
    end
    pulse_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_run: got %b want 1", running); end
    repeat (5) pulse_1hz();
    total++; if (an !== 4'b1110 || seg !== 7'b0010010) begin
      bad++; $display("FAIL count5: got an=%b seg=%b want an=1110 seg=0010010", an, seg);
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 8; i++) begin
      pulse_500();
      total++; if (an !== exp_an(m_scan)) begin
        bad++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, exp_an(m_scan));
      end
      total++; if (dp !== ((m_scan == 2) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL scan_dp[%0d]: got %b want %b", i, dp, (m_scan == 2) ? 1'b0 : 1'b1);
      end
      total++; if (seg !== digit_pattern(exp_digit(m_secs, m_scan))) begin
        bad++; $display("FAIL scan_seg[%0d]: got %b want %b", i, seg, digit_pattern(exp_digit(m_secs, m_scan)));
      end
    end
  endtask

  task automatic test_random();
    int v;
    int n;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_start();
      end else begin
        n = $urandom_range(1, 40);
        repeat (n) pulse_1hz();
      end
      total++; if (running !== m_run) begin
        bad++; $display("FAIL rand_run[%0d]: got %b want %b", it, running, m_run);
      end
    end
    read_display(v);
    total++; if (v !== exp_mmss()) begin
      bad++; $display("FAIL rand_value: got %0d want %0d", v, exp_mmss());
    end
  endtask

  task automatic test_rollover();
    int v;
    pulse_clear();
    set_running(1'b1);
    repeat (3599) pulse_1hz();
    read_display(v);
    total++; if (v !== 5959) begin bad++; $display("FAIL preload: got %0d want 5959", v); end
    Clock1Hz = 1'b1;
    @(negedge clock);
    total++; if (rollover !== 1'b0) begin bad++; $display("FAIL roll_early: got %b want 0", rollover); end
    Clock1Hz = 1'b0;
    @(negedge clock);
    total++; if (rollover !== 1'b1) begin bad++; $display("FAIL roll_pulse: got %b want 1", rollover); end
    @(negedge clock);
    total++; if (rollover !== 1'b0) begin bad++; $display("FAIL roll_late: got %b want 0", rollover); end
    m_secs = 0;
    read_display(v);
    total++; if (v !== 0 || running !== 1'b1) begin
      bad++; $display("FAIL wrap_value: got %0d run=%b want 0 run=1", v, running);
    end
  endtask

  task automatic test_clear_tick();
    int v;
    pulse_clear();
    set_running(1'b1);
    repeat (9) pulse_1hz();
    read_display(v);
    total++; if (v !== 9) begin bad++; $display("FAIL pre_clear: got %0d want 9", v); end
    // clear lands in the same cycle as the registered 1 Hz tick
    Clock1Hz = 1'b1;
    @(negedge clock);
    Clock1Hz = 1'b0;
    clear    = 1'b1;
    @(negedge clock);
    clear    = 1'b0;
    m_secs   = 0;
    total++; if (rollover !== 1'b0) begin bad++; $display("FAIL clear_roll: got %b want 0", rollover); end
    @(negedge clock);
    read_display(v);
    total++; if (v !== 0) begin bad++; $display("FAIL clear_tick: got %0d want 0", v); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL clear_run: got %b want 1", running); end
  endtask

  task automatic test_reset_midcount();
    int v;
    pulse_clear();
    set_running(1'b1);
    repeat (754) pulse_1hz();
    read_display(v);
    total++; if (v !== 1234) begin bad++; $display("FAIL pre_reset: got %0d want 1234", v); end
    clock500Hz = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    total++; if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      bad++; $display("FAIL mid_rst_pins: got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    total++; if (running !== 1'b0 || rollover !== 1'b0) begin
      bad++; $display("FAIL mid_rst_flags: got run=%b roll=%b want 0 0", running, rollover);
    end
    reset_n = 1'b1;
    m_secs = 0; m_run = 1'b0; m_scan = 0;
    @(negedge clock);
    total++; if (an !== 4'b1110 || seg !== 7'b1000000) begin
      bad++; $display("FAIL mid_rel: got an=%b seg=%b want 1110 1000000", an, seg);
    end
    repeat (4) @(negedge clock);
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL no_false_edge: got %b want 1110", an); end
    clock500Hz = 1'b0;
    @(negedge clock);
    pulse_500();
    total++; if (an !== exp_an(m_scan)) begin
      bad++; $display("FAIL first_scan: got %b want %b", an, exp_an(m_scan));
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_scan();
    test_random();
    test_rollover();
    test_clear_tick();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
